logic_unit_arbiter: RTL

//   Shares one logic unit (AND/OR/NOT/XOR, 2-bit opcode) between NUM_REQ requesters in the EX stage.

---
 rtl/logic_unit_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one 32-bit logic unit (AND/OR/NOT/XOR) between NUM_REQ requesters.
//   A round-robin arbiter picks one valid request per cycle; the selected
//   operation is evaluated combinationally and the result is registered,
//   then presented with the id of the requester that produced it.
//   Sustains one operation per cycle; a stalled consumer back-pressures all
//   requesters.
// Ports
//   clk, rst     clock and synchronous active-high reset
//   req_valid    per-requester valid
//   req_ready    one-hot accept (combinational)
//   req_src/dst  32-bit operands, requester i at [32*i +: 32]
//   req_op       2-bit opcode, requester i at [2*i +: 2]
//   res_valid    result register holds an unconsumed result
//   res_ready    consumer takes the result this cycle
//   res_data     registered result
//   res_id       index of the requester that produced res_data
//   stall_cnt    saturating count of cycles with res_valid & !res_ready
module logic_unit_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned STALL_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_src,
    input  logic [32*NUM_REQ-1:0]   req_dst,
    input  logic [2*NUM_REQ-1:0]    req_op,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_data,
    output logic [ID_W-1:0]         res_id,
    output logic [STALL_W-1:0]      stall_cnt
);

    logic                res_valid_q, res_valid_d;
    logic [31:0]         res_data_q, res_data_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic                can_accept;
    logic                grant_valid;
    logic [ID_W-1:0]     grant_idx;
    logic                found_hi, found_lo;
    logic [ID_W-1:0]     grant_hi, grant_lo;
    logic                accept;
    logic [31:0]         sel_src, sel_dst, alu_res;
    logic [1:0]          sel_op;

    assign can_accept = !res_valid_q || res_ready;

    // Round-robin: the lowest valid index above rr_ptr wins; if none, the
    // lowest valid index at or below rr_ptr wins (wrap-around).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        grant_hi = '0;
        grant_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    grant_hi = ID_W'(i);
                end else begin
                    found_lo = 1'b1;
                    grant_lo = ID_W'(i);
                end
            end
        end
        grant_valid = found_hi || found_lo;
        grant_idx   = found_hi ? grant_hi : grant_lo;
    end

    // Ready is suppressed while rst is high so nothing looks accepted during reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && can_accept && grant_valid && (grant_idx == ID_W'(i));
        end
    end

    assign accept = |req_ready;

    // Operand mux for the granted requester.
    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_op  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_src = req_src[32*i +: 32];
                sel_dst = req_dst[32*i +: 32];
                sel_op  = req_op[2*i +: 2];
            end
        end
    end

    always_comb begin
        unique case (sel_op)
            2'b00: alu_res = sel_dst & sel_src;
            2'b01: alu_res = sel_dst | sel_src;
            2'b10: alu_res = ~sel_src;
            2'b11: alu_res = sel_dst ^ sel_src;
        endcase
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        if (res_valid_q && !res_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
        if (accept) begin
            // Covers both an empty slot and a same-cycle drain-and-refill.
            res_valid_d = 1'b1;
            res_data_d  = alu_res;
            res_id_d    = grant_idx;
            rr_ptr_d    = grant_idx;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            stall_cnt_q <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign stall_cnt = stall_cnt_q;

endmodule
